// File: rtl/ttc_timer_counter_lite8.sv
//------------------------------------------------------------------------------
// Module  : ttc_timer_counter_lite8
// Purpose : Single-channel timer/counter for the ttc8 slice. It holds the
//           APB-programmed control, prescaler, interval and match registers.
//           It produces the interval, match and overflow pulses and the
//           restart strobe for the timer interrupt stage.
// Ports   : pclk8 / n_p_reset8  - clock, asynchronous active-low reset
//           pwdata8             - APB write data
//           *_sel8              - register write strobes (match one-hot 1..3)
//           counter_val8        - current count
//           *_reg_out8          - control / prescaler readback
//           *_intr8, restart8   - registered one-cycle pulses
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ttc_timer_counter_lite8 #(
  parameter int CNT_W = 16
) (
  input  logic             pclk8,
  input  logic             n_p_reset8,
  input  logic [CNT_W-1:0] pwdata8,
  input  logic             cntr_ctrl_reg_sel8,
  input  logic             clk_ctrl_reg_sel8,
  input  logic             interval_reg_sel8,
  input  logic [2:0]       match_reg_sel8,
  output logic [CNT_W-1:0] counter_val8,
  output logic [4:0]       cntr_ctrl_reg_out8,
  output logic [3:0]       clk_ctrl_reg_out8,
  output logic             interval_intr8,
  output logic [2:0]       match_intr8,
  output logic             overflow_intr8,
  output logic             restart8
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  // cntr_ctrl: [0] disable, [1] interval mode, [2] decrement, [3] match enable.
  // The restart bit is a pure strobe and is never stored.
  logic [3:0]       cntr_ctrl;
  logic [3:0]       clk_ctrl;
  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] match_reg [3];
  logic [CNT_W-1:0] count;
  logic [7:0]       prescaler;

  logic             enabled;
  logic             restart_req;
  logic [7:0]       presc_mask;
  logic             tick;
  logic [CNT_W-1:0] next_cnt;
  logic             hit_interval;
  logic             hit_overflow;
  logic [2:0]       hit_match;
  logic [CNT_W-1:0] restart_val;

  assign enabled     = ~cntr_ctrl[0];
  assign restart_req = cntr_ctrl_reg_sel8 & pwdata8[4];

  // Tick period is 2^(N+1) pclk: fires when the low N+1 prescaler bits are all ones.
  assign presc_mask = 8'((9'd2 << clk_ctrl[3:1]) - 9'd1);
  assign tick       = enabled & (~clk_ctrl[0] | ((prescaler & presc_mask) == presc_mask));

  // Restart reload uses the mode bits being written, so a mode change and
  // restart issued together start cleanly in the new mode.
  assign restart_val = pwdata8[2] ? (pwdata8[1] ? interval : ALL_ONES) : '0;

  always_comb begin
    next_cnt     = count;
    hit_interval = 1'b0;
    hit_overflow = 1'b0;
    if (!cntr_ctrl[2]) begin
      if (cntr_ctrl[1] && (count == interval)) begin
        next_cnt     = '0;
        hit_interval = 1'b1;
      end else if (count == ALL_ONES) begin
        next_cnt     = '0;
        hit_overflow = 1'b1;
      end else begin
        next_cnt = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        if (cntr_ctrl[1]) begin
          next_cnt     = interval;
          hit_interval = 1'b1;
        end else begin
          next_cnt     = ALL_ONES;
          hit_overflow = 1'b1;
        end
      end else begin
        next_cnt = count - 1'b1;
      end
    end
  end

  always_comb begin
    hit_match = 3'b000;
    for (int i = 0; i < 3; i++) begin
      hit_match[i] = cntr_ctrl[3] & (next_cnt == match_reg[i]);
    end
  end

  always_ff @(posedge pclk8 or negedge n_p_reset8) begin
    if (!n_p_reset8) begin
      cntr_ctrl      <= 4'b0001;
      clk_ctrl       <= 4'h0;
      interval       <= '0;
      match_reg[0]   <= '0;
      match_reg[1]   <= '0;
      match_reg[2]   <= '0;
      count          <= '0;
      prescaler      <= 8'h00;
      interval_intr8 <= 1'b0;
      match_intr8    <= 3'b000;
      overflow_intr8 <= 1'b0;
      restart8       <= 1'b0;
    end else begin
      interval_intr8 <= 1'b0;
      match_intr8    <= 3'b000;
      overflow_intr8 <= 1'b0;
      restart8       <= 1'b0;

      if (cntr_ctrl_reg_sel8) cntr_ctrl <= pwdata8[3:0];
      if (clk_ctrl_reg_sel8)  clk_ctrl  <= pwdata8[3:0];
      if (interval_reg_sel8)  interval  <= pwdata8;
      for (int i = 0; i < 3; i++) begin
        if (match_reg_sel8[i]) match_reg[i] <= pwdata8;
      end

      // Restart wins over any coincident tick and suppresses its pulses.
      if (restart_req) begin
        count     <= restart_val;
        prescaler <= 8'h00;
        restart8  <= 1'b1;
      end else if (enabled) begin
        prescaler <= prescaler + 8'h01;
        if (tick) begin
          count          <= next_cnt;
          interval_intr8 <= hit_interval;
          overflow_intr8 <= hit_overflow;
          match_intr8    <= hit_match;
        end
      end else begin
        prescaler <= 8'h00;
      end
    end
  end

  assign counter_val8       = count;
  assign cntr_ctrl_reg_out8 = {1'b0, cntr_ctrl};
  assign clk_ctrl_reg_out8  = clk_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_ttc_timer_counter_lite8.sv
//------------------------------------------------------------------------------
// Module  : tb_ttc_timer_counter_lite8
// Purpose : Self-checking bench for ttc_timer_counter_lite8: directed scenarios
//           followed by random register traffic, compared every cycle against
//           a behavioural model of the counter rules.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ttc_timer_counter_lite8;

  logic        pclk8;
  logic        n_p_reset8;
  logic [15:0] pwdata8;
  logic        cntr_ctrl_reg_sel8;
  logic        clk_ctrl_reg_sel8;
  logic        interval_reg_sel8;
  logic [2:0]  match_reg_sel8;
  logic [15:0] counter_val8;
  logic [4:0]  cntr_ctrl_reg_out8;
  logic [3:0]  clk_ctrl_reg_out8;
  logic        interval_intr8;
  logic [2:0]  match_intr8;
  logic        overflow_intr8;
  logic        restart8;

  ttc_timer_counter_lite8 #(.CNT_W(16)) dut (
    .pclk8              (pclk8),
    .n_p_reset8         (n_p_reset8),
    .pwdata8            (pwdata8),
    .cntr_ctrl_reg_sel8 (cntr_ctrl_reg_sel8),
    .clk_ctrl_reg_sel8  (clk_ctrl_reg_sel8),
    .interval_reg_sel8  (interval_reg_sel8),
    .match_reg_sel8     (match_reg_sel8),
    .counter_val8       (counter_val8),
    .cntr_ctrl_reg_out8 (cntr_ctrl_reg_out8),
    .clk_ctrl_reg_out8  (clk_ctrl_reg_out8),
    .interval_intr8     (interval_intr8),
    .match_intr8        (match_intr8),
    .overflow_intr8     (overflow_intr8),
    .restart8           (restart8)
  );

  initial pclk8 = 1'b0;
  always #5 pclk8 = ~pclk8;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit [3:0] m_ctrl;
  bit [3:0] m_clk;
  int       m_intv;
  int       m_match [3];
  int       m_cnt;
  int       m_since;   // pclk cycles since the prescaler was last cleared
  bit       e_intv, e_ovf, e_rst;
  bit [2:0] e_match;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 4'b0001; m_clk = 4'h0; m_intv = 0;
    m_match[0] = 0; m_match[1] = 0; m_match[2] = 0;
    m_cnt = 0; m_since = 0;
    e_intv = 0; e_ovf = 0; e_rst = 0; e_match = 3'b000;
  endtask

  // Applies one pclk edge of the counter rules to the model, using the
  // inputs as they stood at that edge.
  task automatic model_edge();
    bit rs, en, tk;
    int per, nxt;
    rs  = cntr_ctrl_reg_sel8 && pwdata8[4];
    en  = !m_ctrl[0];
    per = 1 << (int'(m_clk[3:1]) + 1);
    tk  = en && (!m_clk[0] || ((m_since % per) == per - 1));
    e_intv = 0; e_ovf = 0; e_rst = 0; e_match = 3'b000;
    if (rs) begin
      m_cnt   = pwdata8[2] ? (pwdata8[1] ? m_intv : 65535) : 0;
      m_since = 0;
      e_rst   = 1;
    end else if (en) begin
      if (tk) begin
        if (!m_ctrl[2]) begin
          if (m_ctrl[1] && m_cnt == m_intv) begin
            nxt = 0; e_intv = 1;
          end else begin
            nxt = (m_cnt + 1) % 65536; e_ovf = (m_cnt == 65535);
          end
        end else if (m_cnt == 0) begin
          if (m_ctrl[1]) begin nxt = m_intv; e_intv = 1; end
          else begin nxt = 65535; e_ovf = 1; end
        end else begin
          nxt = m_cnt - 1;
        end
        if (m_ctrl[3])
          for (int i = 0; i < 3; i++) e_match[i] = (nxt == m_match[i]);
        m_cnt = nxt;
      end
      m_since++;
    end else begin
      m_since = 0;
    end
    if (cntr_ctrl_reg_sel8) m_ctrl = pwdata8[3:0];
    if (clk_ctrl_reg_sel8)  m_clk  = pwdata8[3:0];
    if (interval_reg_sel8)  m_intv = int'(pwdata8);
    for (int i = 0; i < 3; i++) if (match_reg_sel8[i]) m_match[i] = int'(pwdata8);
  endtask

  task automatic check_all();
    chk("counter_val8",  32'(counter_val8),       32'(m_cnt));
    chk("interval_intr8", 32'(interval_intr8),    32'(e_intv));
    chk("overflow_intr8", 32'(overflow_intr8),    32'(e_ovf));
    chk("match_intr8",   32'(match_intr8),        32'(e_match));
    chk("restart8",      32'(restart8),           32'(e_rst));
    chk("cntr_ctrl_out", 32'(cntr_ctrl_reg_out8), 32'({1'b0, m_ctrl}));
    chk("clk_ctrl_out",  32'(clk_ctrl_reg_out8),  32'(m_clk));
  endtask

  task automatic cyc();
    @(posedge pclk8);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wr_ctrl(input logic [15:0] d);
    pwdata8 = d; cntr_ctrl_reg_sel8 = 1'b1; cyc(); cntr_ctrl_reg_sel8 = 1'b0;
  endtask
  task automatic wr_clk(input logic [15:0] d);
    pwdata8 = d; clk_ctrl_reg_sel8 = 1'b1; cyc(); clk_ctrl_reg_sel8 = 1'b0;
  endtask
  task automatic wr_intv(input logic [15:0] d);
    pwdata8 = d; interval_reg_sel8 = 1'b1; cyc(); interval_reg_sel8 = 1'b0;
  endtask
  task automatic wr_match(input logic [2:0] sel, input logic [15:0] d);
    pwdata8 = d; match_reg_sel8 = sel; cyc(); match_reg_sel8 = 3'b000;
  endtask

  // Bounded wait for a given count value; an expired bound shows as a failed check.
  task automatic wait_count(input logic [15:0] v, input string tag);
    for (int k = 0; k < 64 && counter_val8 !== v; k++) cyc();
    chk(tag, 32'(counter_val8), 32'(v));
  endtask

  initial begin
    n_p_reset8 = 1'b0; pwdata8 = '0;
    cntr_ctrl_reg_sel8 = 0; clk_ctrl_reg_sel8 = 0; interval_reg_sel8 = 0; match_reg_sel8 = 0;
    model_reset();
    repeat (2) @(posedge pclk8);
    #2 n_p_reset8 = 1'b1;
    #1 check_all();

    // Free-running increment, no prescale
    wr_ctrl(16'h0000);
    run(4);
    chk("inc_step", 32'(counter_val8), 32'd4);
    // Reach all-ones via decrement restart, then switch to increment to wrap
    wr_ctrl(16'h0014);
    wr_ctrl(16'h0000);
    for (int k = 0; k < 8 && overflow_intr8 !== 1'b1; k++) cyc();
    chk("ovf_seen", 32'(overflow_intr8), 32'd1);
    chk("ovf_count", 32'(counter_val8), 32'd0);
    run(2);

    // Interval mode, increment, interval=5
    wr_intv(16'd5);
    wr_ctrl(16'h0012);
    run(14);

    // Decrement + interval with restart, interval=3
    wr_intv(16'd3);
    wr_ctrl(16'h0016);
    chk("dec_restart_val", 32'(counter_val8), 32'd3);
    run(10);

    // Match with prescale N=1
    wr_match(3'b001, 16'd2);
    wr_match(3'b100, 16'd2);
    wr_match(3'b010, 16'd4);
    wr_clk(16'h0003);
    wr_ctrl(16'h0018);
    run(24);

    // Restart coinciding with an interval-reaching tick
    wr_clk(16'h0000);
    wr_intv(16'd5);
    wr_ctrl(16'h0012);
    wait_count(16'd5, "wait_at_interval");
    wr_ctrl(16'h0012);
    chk("rst_tick_count", 32'(counter_val8), 32'd0);
    chk("rst_tick_strobe", 32'(restart8), 32'd1);
    chk("rst_tick_no_intv", 32'(interval_intr8), 32'd0);
    run(3);

    // Disable at 7, re-enable resumes at 8
    wr_ctrl(16'h0010);
    wait_count(16'd6, "wait_six");
    wr_ctrl(16'h0001);
    run(3);
    chk("disabled_hold", 32'(counter_val8), 32'd7);
    wr_ctrl(16'h0000);
    cyc();
    chk("resume", 32'(counter_val8), 32'd8);

    // Random register traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      pwdata8 = 16'($urandom);
      if (r < 4) begin
        pwdata8[0] = ($urandom_range(0, 9) == 0);
        cntr_ctrl_reg_sel8 = 1'b1;
      end else if (r < 7) begin
        clk_ctrl_reg_sel8 = 1'b1;
      end else if (r < 10) begin
        pwdata8 = 16'($urandom_range(0, 20));
        interval_reg_sel8 = 1'b1;
      end else if (r < 14) begin
        pwdata8 = 16'($urandom_range(0, 20));
        match_reg_sel8 = 3'b001 << $urandom_range(0, 2);
      end
      cyc();
      cntr_ctrl_reg_sel8 = 0; clk_ctrl_reg_sel8 = 0; interval_reg_sel8 = 0; match_reg_sel8 = 0;
    end

    // Asynchronous reset mid-count, observed before the next edge
    wr_clk(16'h0000);
    wr_ctrl(16'h0000);
    run(5);
    #2 n_p_reset8 = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge pclk8);
    #2 n_p_reset8 = 1'b1;
    run(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
